// File: rtl/sar_multich_seq_if.sv
// Bus between the SAR sequencer and its surroundings (analog front end + result consumer).
// SAR_OVERRUN_EN adds the overrun flag.
interface sar_multich_seq_if #(
  parameter int NUM_BITS = 4,
  parameter int NUM_CH   = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                enable;
  logic                scan_mode;
  logic                start;
  logic [CH_W-1:0]     ch_sel;
  logic [1:0]          sample_rate;
  logic                cmp_out;
  logic                sample_sig;
  logic [CH_W-1:0]     ch_mux;
  logic [NUM_BITS-1:0] dac_code;
  logic                busy;
  logic [NUM_BITS-1:0] d_out;
  logic [CH_W-1:0]     d_ch;
  logic                eoc;
  logic                ready;
`ifdef SAR_OVERRUN_EN
  logic                overrun;

  modport master (
    input  enable, scan_mode, start, ch_sel, sample_rate, cmp_out, ready,
    output sample_sig, ch_mux, dac_code, busy, d_out, d_ch, eoc, overrun
  );
  modport slave (
    output enable, scan_mode, start, ch_sel, sample_rate, cmp_out, ready,
    input  sample_sig, ch_mux, dac_code, busy, d_out, d_ch, eoc, overrun
  );
`else
  modport master (
    input  enable, scan_mode, start, ch_sel, sample_rate, cmp_out, ready,
    output sample_sig, ch_mux, dac_code, busy, d_out, d_ch, eoc
  );
  modport slave (
    output enable, scan_mode, start, ch_sel, sample_rate, cmp_out, ready,
    input  sample_sig, ch_mux, dac_code, busy, d_out, d_ch, eoc
  );
`endif
endinterface

// File: rtl/sar_multich_seq.sv
// Multi-channel SAR ADC sequencer: mux/S&H control, binary-search trials, valid/ready results.
// Optional SAR_OVERRUN_EN flags results overwritten before they were accepted.
module sar_multich_seq #(
  parameter int NUM_BITS = 4,
  parameter int NUM_CH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  sar_multich_seq_if.master bus
);
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int IDX_W    = $clog2(NUM_BITS);
  localparam int WAIT_MAX = 3 * (NUM_BITS + 1);
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [NUM_BITS-1:0] MSB = {1'b1, {(NUM_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, WAIT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          rate_q, rate_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic                scan_q, scan_d;
  logic [NUM_BITS-1:0] dac_q, dac_d;
  logic [NUM_BITS-1:0] dout_q, dout_d;
  logic [CH_W-1:0]     dch_q, dch_d;
  logic                eoc_q, eoc_d;
`ifdef SAR_OVERRUN_EN
  logic                ovr_q, ovr_d;
`endif

  logic [IDX_W-1:0]    bit_idx;
  logic [NUM_BITS-1:0] trial;
  logic [CH_W-1:0]     ptr_inc, ptr_next;
  logic [CNT_W-1:0]    wait_len;
  logic                done, frame_end;

  assign bit_idx  = IDX_W'(NUM_BITS - 1) - IDX_W'(cnt_q);
  assign ptr_inc  = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
  // Pointer tracks the channel of the current scan frame; it advances only when a scan frame completes.
  assign ptr_next = scan_q ? ptr_inc : ptr_q;
  assign wait_len = CNT_W'(rate_q) * CNT_W'(NUM_BITS + 1);

  always_comb begin
    trial = dac_q;
    if (!bus.cmp_out) trial[bit_idx] = 1'b0;
    if (bit_idx != '0) trial[bit_idx - 1'b1] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rate_d    = rate_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    scan_d    = scan_q;
    dac_d     = dac_q;
    dout_d    = dout_q;
    dch_d     = dch_q;
    eoc_d     = eoc_q;
    done      = 1'b0;
    frame_end = 1'b0;
`ifdef SAR_OVERRUN_EN
    ovr_d     = ovr_q;
`endif
    case (state_q)
      IDLE: if (bus.enable && (bus.scan_mode || bus.start)) begin
        state_d = SAMPLE;
        ch_d    = bus.scan_mode ? ptr_q : bus.ch_sel;
        scan_d  = bus.scan_mode;
      end
      SAMPLE: begin
        rate_d  = bus.sample_rate;
        cnt_d   = '0;
        dac_d   = MSB;
        state_d = CONV;
      end
      CONV: begin
        dac_d = trial;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
          done  = 1'b1;
          dac_d = MSB;
          if (rate_q == 2'b00) frame_end = 1'b1;
          else begin
            state_d = WAIT;
            cnt_d   = wait_len - 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) frame_end = 1'b1;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      ptr_d = ptr_next;
      if (bus.scan_mode) begin
        state_d = SAMPLE;
        ch_d    = ptr_next;
        scan_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    // Disable wins over everything in flight; pending result and scan position survive.
    if (!bus.enable) begin
      state_d = IDLE;
      dac_d   = MSB;
      ptr_d   = ptr_q;
      ch_d    = ch_q;
      done    = 1'b0;
    end

    if (bus.ready && eoc_q) begin
      eoc_d = 1'b0;
`ifdef SAR_OVERRUN_EN
      ovr_d = 1'b0;
`endif
    end
    if (done) begin
      dout_d = trial;
      dch_d  = ch_q;
      eoc_d  = 1'b1;
`ifdef SAR_OVERRUN_EN
      if (eoc_q && !bus.ready) ovr_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rate_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      scan_q  <= 1'b0;
      dac_q   <= MSB;
      dout_q  <= '0;
      dch_q   <= '0;
      eoc_q   <= 1'b0;
`ifdef SAR_OVERRUN_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      scan_q  <= scan_d;
      dac_q   <= dac_d;
      dout_q  <= dout_d;
      dch_q   <= dch_d;
      eoc_q   <= eoc_d;
`ifdef SAR_OVERRUN_EN
      ovr_q   <= ovr_d;
`endif
    end
  end

  assign bus.sample_sig = (state_q == SAMPLE);
  assign bus.ch_mux     = ch_q;
  assign bus.dac_code   = dac_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.d_out      = dout_q;
  assign bus.d_ch       = dch_q;
  assign bus.eoc        = eoc_q;
`ifdef SAR_OVERRUN_EN
  assign bus.overrun    = ovr_q;
`endif
endmodule

// File: tb/tb_sar_multich_seq.sv
// Directed bench for sar_multich_seq (NUM_BITS=4, NUM_CH=4); overrun checks only with SAR_OVERRUN_EN.
module tb_sar_multich_seq;
  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  sar_multich_seq_if #(.NUM_BITS(4), .NUM_CH(4)) bus ();
  sar_multich_seq #(.NUM_BITS(4), .NUM_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.enable = 1'b0; bus.scan_mode = 1'b0; bus.start = 1'b0; bus.ch_sel = '0;
    bus.sample_rate = 2'b00; bus.cmp_out = 1'b0; bus.ready = 1'b0;
    tick; tick;
    checks++;
    if ({bus.sample_sig, bus.busy, bus.eoc, bus.dac_code, bus.d_out, bus.ch_mux, bus.d_ch} !== {3'b000, 4'b1000, 4'b0000, 2'd0, 2'd0}) begin
      errs++;
      $display("FAIL reset: got s=%b b=%b e=%b dac=%b d=%b ch=%0d dch=%0d required 0 0 0 1000 0000 0 0",
               bus.sample_sig, bus.busy, bus.eoc, bus.dac_code, bus.d_out, bus.ch_mux, bus.d_ch);
    end
`ifdef SAR_OVERRUN_EN
    checks++;
    if (bus.overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b required 0", bus.overrun); end
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_shot;
    logic [3:0] exp_dac [4] = '{4'b1000, 4'b1100, 4'b1010, 4'b1011};
    logic       cmp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.ch_sel = 2'd2; bus.start = 1'b1; bus.enable = 1'b1;
    tick;
    bus.start = 1'b0;
    checks++;
    if ({bus.sample_sig, bus.busy, bus.ch_mux, bus.dac_code} !== {2'b11, 2'd2, 4'b1000}) begin
      errs++;
      $display("FAIL single_sample: got s=%b b=%b ch=%0d dac=%b required 1 1 2 1000",
               bus.sample_sig, bus.busy, bus.ch_mux, bus.dac_code);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      bus.cmp_out = cmp_seq[k];
      checks++;
      if ({bus.sample_sig, bus.eoc, bus.ch_mux, bus.dac_code} !== {2'b00, 2'd2, exp_dac[k]}) begin
        errs++;
        $display("FAIL single_conv%0d: got s=%b e=%b ch=%0d dac=%b required 0 0 2 %b",
                 k, bus.sample_sig, bus.eoc, bus.ch_mux, bus.dac_code, exp_dac[k]);
      end
    end
    tick;
    checks++;
    if ({bus.eoc, bus.busy, bus.d_out, bus.d_ch, bus.dac_code} !== {2'b10, 4'b1011, 2'd2, 4'b1000}) begin
      errs++;
      $display("FAIL single_result: got e=%b b=%b d=%b dch=%0d dac=%b required 1 0 1011 2 1000",
               bus.eoc, bus.busy, bus.d_out, bus.d_ch, bus.dac_code);
    end
  endtask

  task automatic test_handshake_hold;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.eoc, bus.busy, bus.d_out} !== {2'b10, 4'b1011}) begin
        errs++;
        $display("FAIL hold%0d: got e=%b b=%b d=%b required 1 0 1011", i, bus.eoc, bus.busy, bus.d_out);
      end
    end
    bus.ready = 1'b1;
    tick;
    checks++;
    if ({bus.eoc, bus.d_out} !== {1'b0, 4'b1011}) begin
      errs++;
      $display("FAIL accept: got e=%b d=%b required 0 1011", bus.eoc, bus.d_out);
    end
  endtask

  task automatic test_scan_rates;
    int n, last, cyc;
    bus.scan_mode = 1'b1; bus.ready = 1'b1; bus.cmp_out = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.sample_rate = 2'(r);
      bus.enable = 1'b1;
      n = 0; last = 0; cyc = 0;
      while (n < 5 && cyc < 200) begin
        tick;
        cyc++;
        if (bus.sample_sig) begin
          checks++;
          if (bus.ch_mux !== 2'(n % 4)) begin
            errs++;
            $display("FAIL scan_ch r=%0d n=%0d: got %0d required %0d", r, n, bus.ch_mux, n % 4);
          end
          if (n > 0) begin
            checks++;
            if (cyc - last !== 5 * (r + 1)) begin
              errs++;
              $display("FAIL scan_period r=%0d n=%0d: got %0d required %0d", r, n, cyc - last, 5 * (r + 1));
            end
          end
          last = cyc;
          n++;
          if (n == 5) bus.enable = 1'b0;
        end
      end
      checks++;
      if (n !== 5) begin
        errs++;
        $display("FAIL scan_timeout r=%0d: got %0d strobes required 5", r, n);
      end
      bus.enable = 1'b0;
      tick; tick;
      checks++;
      if (bus.busy !== 1'b0) begin errs++; $display("FAIL scan_stop r=%0d: got busy=%b required 0", r, bus.busy); end
    end
  endtask

  task automatic test_back_to_back;
    bus.enable = 1'b1; bus.scan_mode = 1'b1; bus.sample_rate = 2'b00; bus.ready = 1'b0; bus.cmp_out = 1'b1;
    tick;
    checks++;
    if ({bus.sample_sig, bus.ch_mux} !== {1'b1, 2'd0}) begin
      errs++;
      $display("FAIL b2b_start: got s=%b ch=%0d required 1 0", bus.sample_sig, bus.ch_mux);
    end
    repeat (5) tick;
    checks++;
    if ({bus.eoc, bus.sample_sig, bus.d_out, bus.d_ch} !== {2'b11, 4'b1111, 2'd0}) begin
      errs++;
      $display("FAIL b2b_first: got e=%b s=%b d=%b dch=%0d required 1 1 1111 0",
               bus.eoc, bus.sample_sig, bus.d_out, bus.d_ch);
    end
    bus.cmp_out = 1'b0;
    repeat (4) tick;
    checks++;
    if ({bus.eoc, bus.d_out} !== {1'b1, 4'b1111}) begin
      errs++;
      $display("FAIL b2b_held: got e=%b d=%b required 1 1111", bus.eoc, bus.d_out);
    end
    bus.ready = 1'b1;
    tick;
    checks++;
    if ({bus.eoc, bus.d_out, bus.d_ch} !== {1'b1, 4'b0000, 2'd1}) begin
      errs++;
      $display("FAIL same_edge: got e=%b d=%b dch=%0d required 1 0000 1", bus.eoc, bus.d_out, bus.d_ch);
    end
`ifdef SAR_OVERRUN_EN
    checks++;
    if (bus.overrun !== 1'b0) begin errs++; $display("FAIL same_edge_overrun: got %b required 0", bus.overrun); end
`endif
    bus.ready = 1'b0; bus.cmp_out = 1'b1;
    repeat (5) tick;
    checks++;
    if ({bus.eoc, bus.d_out, bus.d_ch} !== {1'b1, 4'b1111, 2'd2}) begin
      errs++;
      $display("FAIL overwrite: got e=%b d=%b dch=%0d required 1 1111 2", bus.eoc, bus.d_out, bus.d_ch);
    end
`ifdef SAR_OVERRUN_EN
    checks++;
    if (bus.overrun !== 1'b1) begin errs++; $display("FAIL overrun_set: got %b required 1", bus.overrun); end
`endif
    bus.ready = 1'b1;
    tick;
    checks++;
    if (bus.eoc !== 1'b0) begin errs++; $display("FAIL b2b_accept: got e=%b required 0", bus.eoc); end
`ifdef SAR_OVERRUN_EN
    checks++;
    if (bus.overrun !== 1'b0) begin errs++; $display("FAIL overrun_clear: got %b required 0", bus.overrun); end
`endif
    bus.enable = 1'b0; bus.ready = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    logic cmp_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.enable = 1'b1; bus.cmp_out = 1'b1;
    tick;
    checks++;
    if ({bus.sample_sig, bus.ch_mux} !== {1'b1, 2'd3}) begin
      errs++;
      $display("FAIL abort_start: got s=%b ch=%0d required 1 3", bus.sample_sig, bus.ch_mux);
    end
    tick; tick;
    checks++;
    if (bus.dac_code !== 4'b1100) begin errs++; $display("FAIL abort_bit2: got dac=%b required 1100", bus.dac_code); end
    bus.enable = 1'b0;
    tick;
    checks++;
    if ({bus.busy, bus.sample_sig, bus.eoc, bus.dac_code, bus.d_out} !== {3'b000, 4'b1000, 4'b1111}) begin
      errs++;
      $display("FAIL abort_idle: got b=%b s=%b e=%b dac=%b d=%b required 0 0 0 1000 1111",
               bus.busy, bus.sample_sig, bus.eoc, bus.dac_code, bus.d_out);
    end
    tick;
    bus.enable = 1'b1;
    tick;
    checks++;
    if ({bus.sample_sig, bus.ch_mux} !== {1'b1, 2'd3}) begin
      errs++;
      $display("FAIL abort_resume: got s=%b ch=%0d required 1 3", bus.sample_sig, bus.ch_mux);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      bus.cmp_out = cmp_seq[k];
    end
    tick;
    checks++;
    if ({bus.eoc, bus.d_out, bus.d_ch} !== {1'b1, 4'b1011, 2'd3}) begin
      errs++;
      $display("FAIL abort_result: got e=%b d=%b dch=%0d required 1 1011 3", bus.eoc, bus.d_out, bus.d_ch);
    end
    bus.enable = 1'b0; bus.ready = 1'b1;
    tick; tick;
    bus.ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bus.scan_mode = 1'b0; bus.ch_sel = 2'd1; bus.start = 1'b1; bus.enable = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (5) tick;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({bus.busy, bus.sample_sig, bus.eoc, bus.dac_code, bus.d_out, bus.ch_mux} !== {3'b000, 4'b1000, 4'b0000, 2'd0}) begin
      errs++;
      $display("FAIL reset_mid: got b=%b s=%b e=%b dac=%b d=%b ch=%0d required 0 0 0 1000 0000 0",
               bus.busy, bus.sample_sig, bus.eoc, bus.dac_code, bus.d_out, bus.ch_mux);
    end
    rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_shot;
    test_handshake_hold;
    test_scan_rates;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
